alu_execute: RTL and testbench

ALU_EXECUTE -- requirements
Module: alu_execute

---
 rtl/alu_execute.sv | 158 +++++++++++++++
 tb/tb_alu_execute.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift ops plus a 32-cycle
// iterative signed multiplier that stalls the pipeline through busy.
module alu_execute (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [2:0]  AluControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [4:0]  shamt,
  input  logic        flush,
  output logic [31:0] AluResult,
  output logic        Zero,
  output logic        valid_out,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] alu_res;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc_sum;
  logic [63:0] prod;

  always_comb begin
    alu_res = 32'd0;
    case (AluControl)
      OP_ADD:  alu_res = SrcA + SrcB;
      OP_SUB:  alu_res = SrcA - SrcB;
      OP_AND:  alu_res = SrcA & SrcB;
      OP_OR:   alu_res = SrcA | SrcB;
      OP_SLT:  alu_res = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
      OP_SLL:  alu_res = SrcB << shamt;
      OP_SRL:  alu_res = SrcB >> shamt;
      default: alu_res = 32'd0;
    endcase
  end

  // The multiplier works on magnitudes; the sign is restored once at the end.
  assign a_mag = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
  assign b_mag = SrcB[31] ? (~SrcB + 32'd1) : SrcB;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_sum  = acc_q + (mb_q[0] ? ma_q : 64'd0);
    prod     = neg_q ? (~acc_sum + 64'd1) : acc_sum;

    case (state_q)
      IDLE: begin
        if (valid_in && !flush) begin
          if (AluControl == OP_MULT) begin
            ma_d    = {32'd0, a_mag};
            mb_d    = b_mag;
            acc_d   = 64'd0;
            cnt_d   = 5'd0;
            neg_d   = SrcA[31] ^ SrcB[31];
            state_d = MULT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
            valid_d  = 1'b1;
          end
        end
      end
      MULT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_sum;
          ma_d  = ma_q << 1;
          mb_d  = mb_q >> 1;
          cnt_d = cnt_q + 5'd1;
          // Last iteration: publish the signed product so DONE shows it.
          if (cnt_q == 5'd31) begin
            hi_d     = prod[63:32];
            lo_d     = prod[31:0];
            result_d = prod[31:0];
            zero_d   = (prod[31:0] == 32'd0);
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      ma_q     <= 64'd0;
      mb_q     <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign AluResult = result_q;
  assign Zero      = zero_q;
  assign valid_out = valid_q;
  assign busy      = (state_q == MULT);
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_execute.sv
// Self-checking bench for alu_execute: a transaction-level model checked every
// cycle, plus literal expectations on directed vectors.
module tb_alu_execute;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [2:0]  AluControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  shamt;
  logic        flush;
  logic [31:0] AluResult;
  logic        Zero;
  logic        valid_out;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  alu_execute dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .AluControl(AluControl),
    .SrcA(SrcA), .SrcB(SrcB), .shamt(shamt), .flush(flush),
    .AluResult(AluResult), .Zero(Zero), .valid_out(valid_out), .busy(busy),
    .HI(HI), .LO(LO)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: a mult is a countdown of 32 busy cycles followed by one result cycle.
  int          m_cnt = 0;
  bit          m_done = 0;
  logic [63:0] m_prod = 64'd0;
  logic [31:0] exp_result = 32'd0;
  logic        exp_zero = 1'b1;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return b << sh;
      3'b101:  return b >> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] multModel(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_done <= 0;
      exp_result <= 32'd0; exp_zero <= 1'b1; exp_valid <= 1'b0;
      exp_hi <= 32'd0; exp_lo <= 32'd0;
    end else begin
      exp_valid <= 1'b0;
      if (flush) begin
        m_cnt <= 0; m_done <= 0;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1; exp_valid <= 1'b1;
          exp_hi <= m_prod[63:32]; exp_lo <= m_prod[31:0];
          exp_result <= m_prod[31:0]; exp_zero <= (m_prod[31:0] == 32'd0);
        end
      end else if (m_done) begin
        m_done <= 0;
      end else if (valid_in) begin
        if (AluControl == 3'b100) begin
          m_prod <= multModel(SrcA, SrcB);
          m_cnt <= 32;
        end else begin
          exp_result <= aluModel(AluControl, SrcA, SrcB, shamt);
          exp_zero <= (aluModel(AluControl, SrcA, SrcB, shamt) == 32'd0);
          exp_valid <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_AluResult", {32'd0, AluResult}, {32'd0, exp_result});
      checkOutput("model_Zero", {63'd0, Zero}, {63'd0, exp_zero});
      checkOutput("model_valid_out", {63'd0, valid_out}, {63'd0, exp_valid});
      checkOutput("model_busy", {63'd0, busy}, {63'd0, (m_cnt > 0)});
      checkOutput("model_HI", {32'd0, HI}, {32'd0, exp_hi});
      checkOutput("model_LO", {32'd0, LO}, {32'd0, exp_lo});
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic fl);
    reset = rst; valid_in = v; AluControl = op; SrcA = a; SrcB = b; shamt = sh; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 3'b010, 32'd0, 32'd0, 5'd0, 0);
  endtask

  task automatic op1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] exp);
    applyStimulus(0, 1, op, a, b, sh, 0);
    checkOutput("lit_result", {32'd0, AluResult}, {32'd0, exp});
    checkOutput("lit_valid", {63'd0, valid_out}, 64'd1);
  endtask

  // Wait for valid_out with a cycle budget; reports cycle index and busy count.
  task automatic waitValid(input int max, output int cyc, output int busy_cnt);
    cyc = 1; busy_cnt = 0;
    while (!valid_out && cyc < max) begin
      if (busy) busy_cnt++;
      idle();
      cyc++;
    end
    checkOutput("valid_timeout", {63'd0, valid_out}, 64'd1);
  endtask

  initial begin
    int cyc;
    int bc;
    reset = 1; valid_in = 0; AluControl = 3'b010; SrcA = 0; SrcB = 0; shamt = 0; flush = 0;
    @(negedge clk);
    checking = 1;
    applyStimulus(1, 1, 3'b010, 32'd1, 32'd1, 5'd0, 1);
    checkOutput("reset_result", {32'd0, AluResult}, 64'd0);
    checkOutput("reset_zero", {63'd0, Zero}, 64'd1);
    checkOutput("reset_busy_valid", {62'd0, busy, valid_out}, 64'd0);

    op1(3'b010, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000);
    checkOutput("add_zero", {63'd0, Zero}, 64'd0);
    op1(3'b110, 32'd5, 32'd5, 5'd0, 32'd0);
    checkOutput("sub_zero", {63'd0, Zero}, 64'd1);
    op1(3'b000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 32'h00F0_F000);
    op1(3'b001, 32'hF000_0001, 32'h0000_1000, 5'd0, 32'hF000_1001);
    op1(3'b111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1);
    op1(3'b111, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0);
    op1(3'b011, 32'd0, 32'd1, 5'd31, 32'h80000000);
    op1(3'b101, 32'd0, 32'h80000000, 5'd31, 32'd1);
    op1(3'b011, 32'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    op1(3'b101, 32'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    idle();

    applyStimulus(0, 1, 3'b100, 32'hFFFFFFFD, 32'd7, 5'd0, 0);
    waitValid(40, cyc, bc);
    checkOutput("mult_latency", cyc, 64'd33);
    checkOutput("mult_busy_cycles", bc, 64'd32);
    checkOutput("mult_hi", {32'd0, HI}, 64'hFFFFFFFF);
    checkOutput("mult_lo", {32'd0, LO}, 64'hFFFFFFEB);
    idle();

    applyStimulus(0, 1, 3'b100, 32'h80000000, 32'h80000000, 5'd0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 3'b010, 32'd9, 32'd9, 5'd0, 0);
    waitValid(40, cyc, bc);
    checkOutput("minmult_hi", {32'd0, HI}, 64'h40000000);
    checkOutput("minmult_result", {32'd0, AluResult}, 64'd0);
    idle();

    applyStimulus(0, 1, 3'b100, 32'd12345, 32'd678, 5'd0, 0);
    for (int i = 0; i < 9; i++) idle();
    applyStimulus(0, 0, 3'b010, 32'd0, 32'd0, 5'd0, 1);
    checkOutput("flush_busy_valid", {62'd0, busy, valid_out}, 64'd0);
    checkOutput("flush_hi", {32'd0, HI}, 64'h40000000);
    for (int i = 0; i < 35; i++) idle();

    applyStimulus(0, 1, 3'b100, 32'd100, 32'd200, 5'd0, 0);
    for (int i = 0; i < 19; i++) idle();
    applyStimulus(1, 0, 3'b010, 32'd0, 32'd0, 5'd0, 0);
    checkOutput("rst_mult_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_mult_zero", {63'd0, Zero}, 64'd1);
    op1(3'b010, 32'd2, 32'd3, 5'd0, 32'd5);

    applyStimulus(0, 1, 3'b010, 32'd7, 32'd7, 5'd0, 1);
    checkOutput("flush_discard_valid", {63'd0, valid_out}, 64'd0);
    checkOutput("flush_discard_result", {32'd0, AluResult}, 64'd5);

    applyStimulus(0, 1, 3'b100, 32'd2, 32'd3, 5'd0, 0);
    waitValid(40, cyc, bc);
    applyStimulus(0, 1, 3'b010, 32'd1, 32'd1, 5'd0, 0);
    checkOutput("done_ignore_valid", {63'd0, valid_out}, 64'd0);
    checkOutput("done_ignore_result", {32'd0, AluResult}, 64'd6);

    applyStimulus(0, 1, 3'b100, 32'd0, 32'd5, 5'd0, 0);
    waitValid(40, cyc, bc);
    checkOutput("mult0_zero", {63'd0, Zero}, 64'd1);
    idle();
    idle();

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
